// File: rtl/param_bank_scheduler.sv
// Double-buffered parameter store: word-loaded initial bank, per-layer captured update bank,
// and a warm-up/training schedule that swaps the forward path onto the update bank.

module pbs_layer_slice #(
   parameter int DATA_W = 16,
   parameter int WORDS  = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cap,
   input  logic                          clr,
   input  logic [WORDS-1:0][DATA_W-1:0]  din,
   output logic [WORDS-1:0][DATA_W-1:0]  q
);
   logic [WORDS-1:0][DATA_W-1:0] slice_q, slice_d;

   // Clear beats capture so a bank wipe is never partially overwritten.
   always_comb begin
      slice_d = slice_q;
      if (clr)      slice_d = '0;
      else if (cap) slice_d = din;
   end

   always_ff @(posedge clk) begin
      if (reset) slice_q <= '0;
      else       slice_q <= slice_d;
   end

   assign q = slice_q;
endmodule

module param_bank_scheduler #(
   parameter int DATA_W          = 16,
   parameter int NUM_LAYERS      = 3,
   parameter int WORDS_PER_LAYER = 64,
   parameter int LOW_COUNT       = 5,
   parameter int HIGH_COUNT      = 10,
   parameter int DELAY           = 3,
   localparam int N              = NUM_LAYERS * WORDS_PER_LAYER,
   localparam int ADDR_W         = (N > 1) ? $clog2(N) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    init_wr_en,
   input  logic [ADDR_W-1:0]       init_wr_addr,
   input  logic [DATA_W-1:0]       init_wr_data,
   input  logic [N*DATA_W-1:0]     upd_data,
   input  logic [NUM_LAYERS-1:0]   upd_en,
   input  logic                    upd_clear,
   input  logic                    start,
   input  logic                    enable,
   input  logic                    rearm,
   output logic [N*DATA_W-1:0]     params_out,
   output logic                    sel,
   output logic                    swap_pulse,
   output logic                    hold,
   output logic                    busy,
   output logic                    wr_err
);
   typedef enum logic [2:0] {S_IDLE, S_DELAY, S_RUN, S_SWAP, S_HOLD} state_t;

   localparam logic [31:0] D_CYC = 32'(DELAY * (LOW_COUNT + 1));
   localparam logic [31:0] R_CYC = 32'((LOW_COUNT + 1) * HIGH_COUNT);
   localparam logic [31:0] N_U   = 32'(N);

   state_t                              state_q, state_d;
   logic [31:0]                         cnt_q, cnt_d;
   logic                                wr_err_q, wr_err_d;
   logic [N-1:0][DATA_W-1:0]            init_bank_q, init_bank_d;
   logic [NUM_LAYERS-1:0][WORDS_PER_LAYER-1:0][DATA_W-1:0] upd_in, upd_bank;
   logic [N*DATA_W-1:0]                 init_flat, upd_flat;
   logic                                addr_ok;

   assign upd_in  = upd_data;
   assign addr_ok = 32'(init_wr_addr) < N_U;

   for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
      pbs_layer_slice #(.DATA_W(DATA_W), .WORDS(WORDS_PER_LAYER)) u_slice (
         .clk   (clk),
         .reset (reset),
         .cap   (upd_en[k]),
         .clr   (upd_clear),
         .din   (upd_in[k]),
         .q     (upd_bank[k])
      );
   end

   always_comb begin
      init_bank_d = init_bank_q;
      wr_err_d    = wr_err_q;
      if (init_wr_en) begin
         if (state_q == S_IDLE && addr_ok) init_bank_d[init_wr_addr] = init_wr_data;
         else                              wr_err_d = 1'b1;
      end
   end

   // Counters only move on enabled cycles; each phase exits after its full enabled count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d   = '0;
               state_d = (D_CYC == 32'd0) ? S_RUN : S_DELAY;
            end
         end
         S_DELAY: begin
            if (enable) begin
               if (cnt_q + 32'd1 >= D_CYC) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
         end
         S_RUN: begin
            if (enable) begin
               cnt_d = cnt_q + 32'd1;
               if (cnt_q + 32'd1 >= R_CYC) state_d = S_SWAP;
            end
         end
         S_SWAP:  state_d = S_HOLD;
         S_HOLD:  if (rearm) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wr_err_q    <= 1'b0;
         init_bank_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_err_q    <= wr_err_d;
         init_bank_q <= init_bank_d;
      end
   end

   assign sel        = (state_q == S_SWAP) || (state_q == S_HOLD);
   assign swap_pulse = (state_q == S_SWAP);
   assign hold       = (state_q == S_HOLD);
   assign busy       = (state_q == S_DELAY) || (state_q == S_RUN);
   assign wr_err     = wr_err_q;

   assign init_flat  = init_bank_q;
   assign upd_flat   = upd_bank;
   assign params_out = sel ? upd_flat : init_flat;
endmodule

// File: tb/tb_param_bank_scheduler.sv
// Scoreboard bench: stimulus queues expected status/params per cycle, a monitor pops and compares.
module tb_param_bank_scheduler;
   localparam int DW  = 16;
   localparam int NL  = 3;
   localparam int WPL = 4;
   localparam int N   = NL * WPL;
   localparam int NW  = N * DW;
   localparam int AW  = $clog2(N);

   logic          clk = 1'b0;
   logic          reset, init_wr_en, upd_clear, start, enable, rearm;
   logic [AW-1:0] init_wr_addr;
   logic [DW-1:0] init_wr_data;
   logic [NW-1:0] upd_data;
   logic [NL-1:0] upd_en;
   logic [NW-1:0] a_params, b_params;
   logic          a_sel, a_pulse, a_hold, a_busy, a_err;
   logic          b_sel, b_pulse, b_hold, b_busy, b_err;

   always #5 clk = ~clk;

   param_bank_scheduler #(.DATA_W(DW), .NUM_LAYERS(NL), .WORDS_PER_LAYER(WPL),
      .LOW_COUNT(1), .HIGH_COUNT(2), .DELAY(1)) dut_a (
      .clk(clk), .reset(reset), .init_wr_en(init_wr_en), .init_wr_addr(init_wr_addr),
      .init_wr_data(init_wr_data), .upd_data(upd_data), .upd_en(upd_en), .upd_clear(upd_clear),
      .start(start), .enable(enable), .rearm(rearm), .params_out(a_params), .sel(a_sel),
      .swap_pulse(a_pulse), .hold(a_hold), .busy(a_busy), .wr_err(a_err));

   param_bank_scheduler #(.DATA_W(DW), .NUM_LAYERS(NL), .WORDS_PER_LAYER(WPL),
      .LOW_COUNT(1), .HIGH_COUNT(2), .DELAY(0)) dut_b (
      .clk(clk), .reset(reset), .init_wr_en(init_wr_en), .init_wr_addr(init_wr_addr),
      .init_wr_data(init_wr_data), .upd_data(upd_data), .upd_en(upd_en), .upd_clear(upd_clear),
      .start(start), .enable(enable), .rearm(rearm), .params_out(b_params), .sel(b_sel),
      .swap_pulse(b_pulse), .hold(b_hold), .busy(b_busy), .wr_err(b_err));

   // status order: {sel, swap_pulse, hold, busy, wr_err}
   typedef struct {
      logic          which;
      logic [4:0]    st;
      logic          chk_p;
      logic [NW-1:0] p;
      int            tag;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   logic [4:0]    act_st;
   logic [NW-1:0] act_p;
   logic [N-1:0][DW-1:0] m_init, m_upd;

   task automatic tick(input logic which, input logic [4:0] st, input logic chk_p,
                       input logic [NW-1:0] p, input int tag);
      exp_t e;
      e.which = which; e.st = st; e.chk_p = chk_p; e.p = p; e.tag = tag;
      sbq.push_back(e);
      @(negedge clk);
   endtask

   task automatic tick_a(input logic [4:0] st, input int tag);
      tick(1'b0, st, 1'b0, '0, tag);
   endtask

   task automatic tick_ap(input logic [4:0] st, input logic [NW-1:0] p, input int tag);
      tick(1'b0, st, 1'b1, p, tag);
   endtask

   always @(posedge clk) begin
      #1;
      if (sbq.size() > 0) begin
         mon_e  = sbq.pop_front();
         act_st = mon_e.which ? {b_sel, b_pulse, b_hold, b_busy, b_err}
                              : {a_sel, a_pulse, a_hold, a_busy, a_err};
         act_p  = mon_e.which ? b_params : a_params;
         checks++;
         if (act_st !== mon_e.st) begin
            errors++;
            $display("FAIL status tag=%0d dut=%0d got %b expected %b", mon_e.tag, mon_e.which, act_st, mon_e.st);
         end
         if (mon_e.chk_p) begin
            checks++;
            if (act_p !== mon_e.p) begin
               errors++;
               $display("FAIL params tag=%0d dut=%0d got %h expected %h", mon_e.tag, mon_e.which, act_p, mon_e.p);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; init_wr_en = 1'b0; init_wr_addr = '0; init_wr_data = '0;
      upd_data = '0; upd_en = '0; upd_clear = 1'b0; start = 1'b0; enable = 1'b0; rearm = 1'b0;
      m_init = '0; m_upd = '0;
      @(negedge clk);
      tick_ap(5'b00000, m_init, 1);
      tick(1'b1, 5'b00000, 1'b1, '0, 2);
      reset = 1'b0;

      // IDLE write, then an out-of-range write
      init_wr_en = 1'b1; init_wr_addr = 4'd5; init_wr_data = 16'h1234; m_init[5] = 16'h1234;
      tick_ap(5'b00000, m_init, 3);
      init_wr_addr = 4'd12; init_wr_data = 16'hFFFF;
      tick_ap(5'b00001, m_init, 4);
      init_wr_en = 1'b0;
      tick_a(5'b00001, 5);
      reset = 1'b1; m_init = '0;
      tick_ap(5'b00000, m_init, 6);
      reset = 1'b0;
      init_wr_en = 1'b1; init_wr_addr = 4'd5; init_wr_data = 16'h1234; m_init[5] = 16'h1234;
      tick_ap(5'b00000, m_init, 7);
      init_wr_en = 1'b0;

      // Run 1: start at cycle 0, swap in cycle 7
      start = 1'b1; enable = 1'b1;
      tick_a(5'b00010, 10);
      start = 1'b0;
      tick_a(5'b00010, 11);
      tick_a(5'b00010, 12);
      init_wr_en = 1'b1; init_wr_addr = 4'd2; init_wr_data = 16'h5555;
      tick_ap(5'b00011, m_init, 13);
      init_wr_en = 1'b0;
      upd_data = {N{16'hAAAA}}; upd_en = 3'b010;
      for (int i = WPL; i < 2*WPL; i++) m_upd[i] = 16'hAAAA;
      tick_ap(5'b00011, m_init, 14);
      upd_en = '0;
      tick_a(5'b00011, 15);
      tick_ap(5'b11001, m_upd, 16);
      tick_ap(5'b10101, m_upd, 17);
      start = 1'b1;
      tick_a(5'b10101, 18);
      start = 1'b0; rearm = 1'b1;
      tick_ap(5'b00001, m_init, 19);
      rearm = 1'b0;
      reset = 1'b1; m_init = '0; m_upd = '0;
      tick_ap(5'b00000, m_init, 20);
      reset = 1'b0;

      // Run 2: enable low for three RUN cycles, swap in cycle 10; clear beats capture
      start = 1'b1; enable = 1'b1;
      tick_a(5'b00010, 30);
      start = 1'b0; upd_en = 3'b111;
      tick_a(5'b00010, 31);
      upd_en = '0;
      tick_a(5'b00010, 32);
      tick_a(5'b00010, 33);
      enable = 1'b0; upd_en = 3'b111; upd_clear = 1'b1;
      tick_ap(5'b00010, m_init, 34);
      upd_en = '0; upd_clear = 1'b0;
      tick_a(5'b00010, 35);
      tick_a(5'b00010, 36);
      enable = 1'b1;
      tick_a(5'b00010, 37);
      tick_a(5'b00010, 38);
      tick_ap(5'b11000, m_upd, 39);
      tick_a(5'b10100, 40);
      rearm = 1'b1;
      tick_a(5'b00000, 41);
      rearm = 1'b0;

      // Run 3: reset during RUN returns to IDLE with banks cleared
      init_wr_en = 1'b1; init_wr_addr = 4'd0; init_wr_data = 16'hBEEF; m_init[0] = 16'hBEEF;
      tick_ap(5'b00000, m_init, 50);
      init_wr_en = 1'b0; start = 1'b1;
      tick_a(5'b00010, 51);
      start = 1'b0;
      tick_a(5'b00010, 52);
      tick_a(5'b00010, 53);
      tick_a(5'b00010, 54);
      tick_a(5'b00010, 55);
      reset = 1'b1; m_init = '0;
      tick_ap(5'b00000, m_init, 56);
      reset = 1'b0;
      tick_a(5'b00000, 57);

      // DELAY=0 instance goes straight to RUN; rearm while busy is ignored
      start = 1'b1;
      tick(1'b1, 5'b00010, 1'b0, '0, 60);
      start = 1'b0; rearm = 1'b1;
      tick(1'b1, 5'b00010, 1'b0, '0, 61);
      rearm = 1'b0;
      tick(1'b1, 5'b00010, 1'b0, '0, 62);
      tick(1'b1, 5'b00010, 1'b0, '0, 63);
      tick(1'b1, 5'b11000, 1'b1, '0, 64);
      tick(1'b1, 5'b10100, 1'b0, '0, 65);

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
